// File: rtl/mode_sequencer_pkg.sv
// Shared constants for the frame-synchronous mode sequencer and the pattern controller.
package mode_sequencer_pkg;

  localparam logic [1:0] CFG_ADDR_STAGED = 2'd0;
  localparam logic [1:0] CFG_ADDR_MASK   = 2'd1;
  localparam logic [1:0] CFG_ADDR_DWELL  = 2'd2;
  localparam logic [1:0] CFG_ADDR_CTRL   = 2'd3;

  localparam int unsigned CTRL_AUTO   = 0;
  localparam int unsigned CTRL_SCROLL = 1;

  localparam logic [2:0] MODE_PASS    = 3'd0;
  localparam logic [2:0] MODE_BARS    = 3'd1;
  localparam logic [2:0] MODE_CHECKER = 3'd2;
  localparam logic [2:0] MODE_GRAD    = 3'd3;
  localparam logic [2:0] MODE_GRID    = 3'd4;
  localparam logic [2:0] MODE_NOISE   = 3'd5;
  localparam logic [2:0] MODE_RINGS   = 3'd6;
  localparam logic [2:0] MODE_SCROLL  = 3'd7;

  typedef enum logic {
    StManual = 1'b0,
    StAuto   = 1'b1
  } seq_state_e;

endpackage

// File: rtl/mode_sequencer_rr_pick.sv
// Round-robin pick of the next enabled mode after cur; cur itself is considered last.
module mode_rr_pick (
  input  logic [2:0] cur,
  input  logic [7:0] mask,
  output logic [2:0] next,
  output logic       found
);

  logic [2:0]  start;
  logic [15:0] dbl;
  logic [7:0]  rot;
  logic [2:0]  offs;

  always_comb begin
    start = cur + 3'd1;
    dbl   = {mask, mask} >> start;
    rot   = dbl[7:0];
    offs  = 3'd0;
    // Descending scan so the lowest set bit of the rotated mask wins.
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) offs = i[2:0];
    end
    found = |mask;
    next  = start + offs;
  end

endmodule

// File: rtl/mode_sequencer.sv
// Holds live mode params and line offset; commits host or auto-cycle changes only at frame end.
module mode_sequencer
  import mode_sequencer_pkg::*;
#(
  parameter logic [7:0] DEFAULT_DWELL = 8'd60,
  parameter logic [7:0] DEFAULT_MASK  = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_end,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_data,
  output logic [7:0] mode_params,
  output logic [7:0] voffset,
  output logic       mode_change,
  output logic       auto_on
);

  logic [7:0] staged, mask, dwell, dcount, dwell_last;
  logic [1:0] ctrl;
  logic       pending, wr, expire, advance, found;
  logic [2:0] next_mode;
  seq_state_e state;

  mode_rr_pick u_pick (
    .cur   (mode_params[6:4]),
    .mask  (mask),
    .next  (next_mode),
    .found (found)
  );

  // Writes are refused on frame_end so a write never races a commit.
  assign cfg_ready = ~frame_end;
  assign wr        = cfg_valid & cfg_ready;
  assign auto_on   = ctrl[CTRL_AUTO];

  always_comb begin
    state      = ctrl[CTRL_AUTO] ? StAuto : StManual;
    dwell_last = (dwell == 8'd0) ? 8'd0 : dwell - 8'd1;
    expire     = (state == StAuto) && (dcount >= dwell_last);
    advance    = expire && found && (next_mode != mode_params[6:4]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_params <= 8'd0;
      voffset     <= 8'd0;
      mode_change <= 1'b0;
      staged      <= 8'd0;
      pending     <= 1'b0;
      mask        <= DEFAULT_MASK;
      dwell       <= DEFAULT_DWELL;
      ctrl        <= 2'd0;
      dcount      <= 8'd0;
    end else begin
      mode_change <= 1'b0;
      if (wr) begin
        case (cfg_addr)
          CFG_ADDR_STAGED: begin
            staged  <= cfg_data;
            pending <= 1'b1;
          end
          CFG_ADDR_MASK:  mask  <= cfg_data;
          CFG_ADDR_DWELL: dwell <= cfg_data;
          default: begin
            ctrl <= cfg_data[1:0];
            if (cfg_data[CTRL_AUTO] != ctrl[CTRL_AUTO]) dcount <= 8'd0;
          end
        endcase
      end
      if (frame_end) begin
        if (pending) begin
          mode_params <= staged;
          voffset     <= 8'd0;
          pending     <= 1'b0;
          dcount      <= 8'd0;
          mode_change <= 1'b1;
        end else begin
          case (state)
            StAuto:  dcount <= expire ? 8'd0 : dcount + 8'd1;
            default: dcount <= 8'd0;
          endcase
          if (advance) begin
            mode_params[6:4] <= next_mode;
            voffset          <= 8'd0;
            mode_change      <= 1'b1;
          end else if (ctrl[CTRL_SCROLL]) begin
            voffset <= voffset + 8'd1;
          end
        end
      end
    end
  end

endmodule
